// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES round datapath: orders the initial AddRoundKey,
// the full rounds and the final round, and drives the round-key read address for both directions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no block in flight, waiting for start
// WAIT_KEY | block accepted, round keys not yet usable
// LOAD     | capture input block, initial AddRoundKey
// ROUND    | full round (Sub/Shift/Mix/AddKey), round_cnt = 1..NUM_ROUNDS-1
// FINAL    | last round without MixColumns
// HOLD     | result presented, waiting for result_ready

module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int RK_IDX_W   = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic                decrypt,
   input  logic                abort,
   input  logic                key_ready,
   input  logic                stall,
   input  logic                result_ready,
   output logic                load_state,
   output logic                sub_en,
   output logic                shift_en,
   output logic                mix_en,
   output logic                addkey_en,
   output logic                inv,
   output logic [RK_IDX_W-1:0] round_key_idx,
   output logic [RK_IDX_W-1:0] round_cnt,
   output logic                busy,
   output logic                result_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_KEY,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_HOLD
   } state_t;

   localparam logic [RK_IDX_W-1:0] CNT_ONE    = RK_IDX_W'(1);
   localparam logic [RK_IDX_W-1:0] CNT_LAST   = RK_IDX_W'(NUM_ROUNDS);
   localparam logic [RK_IDX_W-1:0] CNT_PENULT = RK_IDX_W'(NUM_ROUNDS - 1);

   state_t              state_q;
   state_t              state_nxt;
   logic [RK_IDX_W-1:0] cnt_q;
   logic [RK_IDX_W-1:0] cnt_nxt;
   logic                mode_q;
   logic                mode_nxt;
   logic                estall;

   // Losing the round keys mid-block pauses the datapath exactly like a downstream stall.
   assign estall = stall | ~key_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         mode_q  <= mode_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      mode_nxt      = mode_q;
      load_state    = 1'b0;
      sub_en        = 1'b0;
      shift_en      = 1'b0;
      mix_en        = 1'b0;
      addkey_en     = 1'b0;
      round_key_idx = '0;
      result_valid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_nxt  = decrypt;
               state_nxt = key_ready ? S_LOAD : S_WAIT_KEY;
            end
         end
         S_WAIT_KEY: begin
            if (key_ready) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            round_key_idx = mode_q ? CNT_LAST : '0;
            if (!estall) begin
               load_state = 1'b1;
               addkey_en  = 1'b1;
               state_nxt  = S_ROUND;
               cnt_nxt    = CNT_ONE;
            end
         end
         S_ROUND: begin
            round_key_idx = mode_q ? (CNT_LAST - cnt_q) : cnt_q;
            if (!estall) begin
               sub_en    = 1'b1;
               shift_en  = 1'b1;
               mix_en    = 1'b1;
               addkey_en = 1'b1;
               if (cnt_q == CNT_PENULT) begin
                  state_nxt = S_FINAL;
                  cnt_nxt   = CNT_LAST;
               end else begin
                  cnt_nxt = cnt_q + CNT_ONE;
               end
            end
         end
         S_FINAL: begin
            round_key_idx = mode_q ? '0 : CNT_LAST;
            if (!estall) begin
               sub_en    = 1'b1;
               shift_en  = 1'b1;
               addkey_en = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Abort outranks everything, including a start arriving in the same IDLE cycle.
      if (abort) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         mode_nxt  = mode_q;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign inv       = mode_q & busy;
   assign round_cnt = cnt_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: cycle-by-cycle output checks for encrypt, decrypt,
// stalls, key loss, abort, result back-pressure, async reset and a 14-round instance.

module tb_aes_round_sequencer;

   localparam int N = 10;
   localparam logic [15:0] EN_MASK = 16'hF800;
   localparam logic [15:0] NO_IDX  = 16'hFC3F;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic       decrypt = 1'b0;
   logic       abort = 1'b0;
   logic       key_ready = 1'b1;
   logic       stall = 1'b0;
   logic       result_ready = 1'b1;
   logic       load_state, sub_en, shift_en, mix_en, addkey_en, inv, busy, result_valid;
   logic [3:0] round_key_idx, round_cnt;
   logic       load_state14, sub_en14, shift_en14, mix_en14, addkey_en14, inv14, busy14, result_valid14;
   logic [3:0] round_key_idx14, round_cnt14;
   logic [15:0] obs;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.NUM_ROUNDS(N), .RK_IDX_W(4)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .abort(abort),
      .key_ready(key_ready), .stall(stall), .result_ready(result_ready),
      .load_state(load_state), .sub_en(sub_en), .shift_en(shift_en), .mix_en(mix_en),
      .addkey_en(addkey_en), .inv(inv), .round_key_idx(round_key_idx), .round_cnt(round_cnt),
      .busy(busy), .result_valid(result_valid)
   );

   aes_round_sequencer #(.NUM_ROUNDS(14), .RK_IDX_W(4)) dut14 (
      .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .abort(abort),
      .key_ready(key_ready), .stall(stall), .result_ready(result_ready),
      .load_state(load_state14), .sub_en(sub_en14), .shift_en(shift_en14), .mix_en(mix_en14),
      .addkey_en(addkey_en14), .inv(inv14), .round_key_idx(round_key_idx14), .round_cnt(round_cnt14),
      .busy(busy14), .result_valid(result_valid14)
   );

   assign obs = {load_state, sub_en, shift_en, mix_en, addkey_en, inv,
                 round_key_idx, round_cnt, busy, result_valid};

   // Expected outputs for cycle c of an undisturbed block (start sampled in cycle 0).
   function automatic logic [15:0] nominal(int c, bit dec, int n);
      logic ld, sb, sh, mx, ak, iv, bz, rv;
      logic [3:0] idx, cnt;
      ld = 0; sb = 0; sh = 0; mx = 0; ak = 0; iv = 0; bz = 0; rv = 0; idx = 0; cnt = 0;
      if (c == 1) begin
         ld = 1; ak = 1; iv = dec; bz = 1;
         idx = dec ? 4'(n) : 4'd0;
      end else if (c >= 2 && c <= n) begin
         sb = 1; sh = 1; mx = 1; ak = 1; iv = dec; bz = 1;
         cnt = 4'(c - 1);
         idx = dec ? 4'(n - c + 1) : 4'(c - 1);
      end else if (c == n + 1) begin
         sb = 1; sh = 1; ak = 1; iv = dec; bz = 1;
         cnt = 4'(n);
         idx = dec ? 4'd0 : 4'(n);
      end else if (c == n + 2) begin
         iv = dec; bz = 1; rv = 1; cnt = 4'(n);
      end
      return {ld, sb, sh, mx, ak, iv, idx, cnt, bz, rv};
   endfunction

   task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e,
                        input logic [15:0] m);
      compared++;
      assert ((o & m) === (e & m)) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
      end
   endtask

   task automatic check_bit(input string tag, input logic o, input logic e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // One block: wk = cycles in WAIT_KEY, stall window at nominal cycle stall_c (via stall or
   // key_ready), hold = extra HOLD cycles with result_ready low and a start pulse inside them.
   task automatic run_block(input string tag, input bit dec, input int wk, input int stall_c,
                            input int stall_len, input bit use_kr, input int hold,
                            input int abort_c);
      int last;
      last = N + 3 + wk + stall_len + hold + 2;
      for (int t = 0; t <= last; t++) begin
         logic [15:0] e, m;
         int  u;
         bit  done, st, krl, rrl, sp;
         @(negedge clk);
         u = t; done = 0; st = 0; krl = 0; rrl = 0; sp = 0; m = 16'hFFFF; e = '0;
         if (wk > 0 && t < wk) krl = 1;
         if (wk > 0 && u >= 1) begin
            if (u <= wk) begin
               e = 16'h0002 | (dec ? 16'h0400 : 16'h0000);
               m = NO_IDX; done = 1;
            end else u -= wk;
         end
         if (!done && stall_c >= 0 && u >= stall_c) begin
            if (u < stall_c + stall_len) begin
               e = nominal(stall_c, dec, N) & ~EN_MASK;
               st = 1; done = 1;
            end else u -= stall_len;
         end
         if (!done && hold > 0 && u >= N + 2) begin
            if (u < N + 2 + hold) begin
               e = nominal(N + 2, dec, N);
               m = NO_IDX; rrl = 1; done = 1;
               if (u == N + 3) sp = 1;
            end else u -= hold;
         end
         if (!done) begin
            e = nominal(u, dec, N);
            if (u == N + 2) m = NO_IDX;
         end
         start        = (t == 0) || sp;
         decrypt      = dec;
         stall        = st && !use_kr;
         key_ready    = !(krl || (st && use_kr));
         result_ready = !rrl;
         abort        = (t == abort_c);
         #1;
         check($sformatf("%s_c%0d", tag, t), obs, e, m);
         if (t == abort_c) break;
      end
   endtask

   initial begin
      #2;
      check("reset_outputs", obs, 16'h0000, 16'hFFFF);
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      check("idle_after_reset", obs, 16'h0000, 16'hFFFF);

      run_block("enc", 1'b0, 0, -1, 0, 1'b0, 0, -1);
      run_block("dec", 1'b1, 0, -1, 0, 1'b0, 0, -1);
      run_block("stall3_cnt4", 1'b0, 0, 5, 3, 1'b0, 0, -1);
      run_block("waitkey_krdrop", 1'b0, 7, 6, 2, 1'b1, 0, -1);
      run_block("abort_cnt5", 1'b0, 0, -1, 0, 1'b0, 0, 6);
      run_block("after_abort", 1'b0, 0, -1, 0, 1'b0, 0, -1);
      run_block("hold4_dec", 1'b1, 0, -1, 0, 1'b0, 4, -1);

      // Abort together with start in IDLE must not launch a block.
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      check("abort_with_start", obs, 16'h0000, 16'hFFFF);

      // Asynchronous reset in the middle of a block.
      @(negedge clk);
      start = 1'b1; decrypt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      check("busy_before_async_reset", obs, nominal(5, 1'b1, N), 16'hFFFF);
      n_rst = 1'b0;
      #1;
      check("async_reset_mid_block", obs, 16'h0000, 16'hFFFF);
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      check("idle_after_async_reset", obs, 16'h0000, 16'hFFFF);

      // 14-round instance: result_valid first high in cycle 16.
      for (int t = 0; t <= 17; t++) begin
         @(negedge clk);
         start   = (t == 0);
         decrypt = 1'b0;
         #1;
         check_bit($sformatf("r14_valid_c%0d", t), result_valid14, (t == 16));
         if (t == 15) check("r14_final_cnt", {12'h000, round_cnt14}, 16'h000E, 16'hFFFF);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
